// File: rtl/bcd_sweep_ctrl_if.sv
// Board controls, decoder inputs/outputs and status of the bcd sweep sequencer.
// master: the sequencer side; slave: the board/decoder side.
interface bcd_sweep_ctrl_if;
  logic       start;
  logic       stop;
  logic       dir;
  logic       auto_repeat;
  logic       err_clr;
  logic       one, two, three, four, five, six, seven, eight, nine;
  logic       a0, a1, a2, a3;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] err_digit;
  logic [7:0] pass_cnt;

  modport master (
    input  start, stop, dir, auto_repeat, err_clr,
    input  one, two, three, four, five, six, seven, eight, nine,
    output a0, a1, a2, a3, busy, done, err, err_digit, pass_cnt
  );

  modport slave (
    output start, stop, dir, auto_repeat, err_clr,
    output one, two, three, four, five, six, seven, eight, nine,
    input  a0, a1, a2, a3, busy, done, err, err_digit, pass_cnt
  );
endinterface

// File: rtl/bcd_sweep_ctrl.sv
// Sweeps a bcd one-hot decoder through digits 0-9 (up or down), holding each
// digit TICK_DIV cycles and checking the decoder outputs at the end of each dwell.
module bcd_sweep_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_sweep_ctrl_if.master sweep
);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned PASS_W = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_MAX  = DIG_W'(9);
  localparam logic [PASS_W-1:0] PASS_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_e;

  state_e              state_q, state_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DIG_W-1:0]    err_digit_q, err_digit_d;
  logic [PASS_W-1:0]   pass_q, pass_d;

  logic [9:1]          dec_c, exp_c;
  logic                last_c, match_c;

  // Expected one-hot code for the digit on the bus; digit 0 expects all zeros.
  always_comb begin
    exp_c = '0;
    for (int unsigned i = 1; i <= 9; i++) begin
      exp_c[i] = (digit_q == DIG_W'(i));
    end
  end

  assign dec_c   = {sweep.nine, sweep.eight, sweep.seven, sweep.six, sweep.five,
                    sweep.four, sweep.three, sweep.two, sweep.one};
  assign match_c = (dec_c == exp_c);
  assign last_c  = dir_q ? (digit_q == DIG_MAX) : (digit_q == '0);

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    err_digit_d = err_digit_q;
    pass_d      = pass_q;

    unique case (state_q)
      S_IDLE: begin
        digit_d = '0;
        if (sweep.start && !sweep.stop) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          dir_d   = sweep.dir;
          digit_d = sweep.dir ? '0 : DIG_MAX;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // stop has priority over the end-of-dwell check
        if (sweep.stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          digit_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!match_c) begin
            state_d     = S_ERR;
            busy_d      = 1'b0;
            err_d       = 1'b1;
            err_digit_d = digit_q;
          end else if (!last_c) begin
            digit_d = dir_q ? digit_q + DIG_W'(1) : digit_q - DIG_W'(1);
          end else begin
            pass_d = (pass_q != PASS_MAX) ? pass_q + PASS_W'(1) : pass_q;
            if (sweep.auto_repeat) begin
              digit_d = dir_q ? '0 : DIG_MAX;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              digit_d = '0;
            end
          end
        end
      end

      S_ERR: begin
        if (sweep.err_clr || sweep.stop) begin
          state_d     = S_IDLE;
          err_d       = 1'b0;
          err_digit_d = '0;
          digit_d     = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      digit_q     <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
      pass_q      <= '0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
      pass_q      <= pass_d;
    end
  end

  assign {sweep.a3, sweep.a2, sweep.a1, sweep.a0} = digit_q;
  assign sweep.busy      = busy_q;
  assign sweep.done      = done_q;
  assign sweep.err       = err_q;
  assign sweep.err_digit = err_digit_q;
  assign sweep.pass_cnt  = pass_q;
endmodule

// File: tb/tb_bcd_sweep_ctrl.sv
// Self-checking bench for bcd_sweep_ctrl: behavioural bcd decoder with injectable
// stuck-at faults, and a sweep-level reference model of digit timing and outcomes.
module tb_bcd_sweep_ctrl;
  localparam int T   = 4;
  localparam int PER = 10 * T;

  logic clk;
  logic rst;
  bcd_sweep_ctrl_if bus ();

  bcd_sweep_ctrl #(.TICK_DIV(T)) dut (
    .clk   (clk),
    .rst   (rst),
    .sweep (bus)
  );

  int n_checks;
  int n_fail;
  int exp_pass;
  int fault_kind;    // 0 none, 1 output stuck at 0, 2 output stuck at 1
  int fault_idx;
  bit exit_by_stop;

  logic [3:0] a_c;
  logic [9:1] dec;

  assign a_c = {bus.a3, bus.a2, bus.a1, bus.a0};

  // Decoder under test, with an optional stuck-at fault on one output.
  always_comb begin
    for (int i = 1; i <= 9; i++) dec[i] = (a_c == 4'(i));
    if (fault_kind == 1) dec[fault_idx] = 1'b0;
    if (fault_kind == 2) dec[fault_idx] = 1'b1;
  end

  assign {bus.nine, bus.eight, bus.seven, bus.six, bus.five,
          bus.four, bus.three, bus.two, bus.one} = dec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dig_of(input bit d, input int w);
    return d ? (w % 10) : (9 - (w % 10));
  endfunction

  function automatic bit bad(input int dg);
    if (fault_kind == 1) return dg == fault_idx;
    if (fault_kind == 2) return dg != fault_idx;
    return 1'b0;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_a"},    int'(a_c),      0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_err"},  int'(bus.err),  0);
  endtask

  // One start pulse followed by ns sweeps (auto_repeat held until the last),
  // optional stop after sample stop_at, optional async reset after sample rst_at.
  task automatic run_sweep(input bit d, input int ns, input int stop_at, input int rst_at);
    int c_end, wf, e, t, kind, done_cnt;
    c_end = ns * PER;
    wf = -1;
    for (int w = 0; w < ns * 10; w++) if (wf < 0 && bad(dig_of(d, w))) wf = w;
    e = (wf >= 0) ? (wf + 1) * T : c_end + 1;
    if (stop_at >= 0 && stop_at + 1 <= e && stop_at + 1 <= c_end) begin
      t = stop_at + 1; kind = 1;
    end else if (wf >= 0) begin
      t = e; kind = 2;
    end else begin
      t = c_end; kind = 0;
    end

    bus.dir = d;
    bus.auto_repeat = (ns > 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < t; k++) begin
      check("digit", int'(a_c), dig_of(d, k / T));
      check("busy_run", int'(bus.busy), 1);
      check("done_run", int'(bus.done), 0);
      check("err_run", int'(bus.err), 0);
      check("pass_run", int'(bus.pass_cnt), sat(exp_pass + k / PER));
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check_idle("rst_async");
        check("rst_err_digit", int'(bus.err_digit), 0);
        check("rst_pass", int'(bus.pass_cnt), 0);
        exp_pass = 0;
        #1 rst = 1'b0;
        bus.auto_repeat = 1'b0;
        tick();
        check_idle("post_rst");
        return;
      end
      bus.stop = (k == stop_at);
      bus.auto_repeat = (k + 1 < c_end);
      bus.dir = 1'($urandom % 2);
      tick();
    end
    bus.stop = 1'b0;

    case (kind)
      0: begin
        exp_pass = sat(exp_pass + ns);
        check("done_pulse", int'(bus.done), 1);
        check("done_busy", int'(bus.busy), 0);
        check("done_a", int'(a_c), 0);
        check("done_pass", int'(bus.pass_cnt), exp_pass);
        tick();
        check("done_once", int'(bus.done), 0);
      end
      1: begin
        done_cnt = (t - 1) / PER;
        exp_pass = sat(exp_pass + done_cnt);
        check_idle("stop");
        check("stop_pass", int'(bus.pass_cnt), exp_pass);
      end
      default: begin
        done_cnt = (e - 1) / PER;
        exp_pass = sat(exp_pass + done_cnt);
        check("err_flag", int'(bus.err), 1);
        check("err_digit", int'(bus.err_digit), dig_of(d, wf));
        check("err_a_hold", int'(a_c), dig_of(d, wf));
        check("err_busy", int'(bus.busy), 0);
        check("err_done", int'(bus.done), 0);
        check("err_pass", int'(bus.pass_cnt), exp_pass);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("err_start_ign", int'(bus.err), 1);
        check("err_start_busy", int'(bus.busy), 0);
        check("err_start_a", int'(a_c), dig_of(d, wf));
        if (exit_by_stop) bus.stop = 1'b1;
        else              bus.err_clr = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.err_clr = 1'b0;
        check_idle("err_exit");
        check("err_exit_digit", int'(bus.err_digit), 0);
      end
    endcase
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_pass = 0;
    fault_kind = 0;
    fault_idx = 1;
    exit_by_stop = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.dir = 1'b0;
    bus.auto_repeat = 1'b0;
    bus.err_clr = 1'b0;
    #12;
    check_idle("reset");
    check("reset_err_digit", int'(bus.err_digit), 0);
    check("reset_pass", int'(bus.pass_cnt), 0);
    rst = 1'b0;
    tick();

    run_sweep(1'b1, 1, -1, -1);          // plain up sweep, done at cycle 40
    run_sweep(1'b0, 4, 3 * PER, -1);     // three down sweeps back to back, then stop

    fault_kind = 1; fault_idx = 5;       // five stuck at 0
    run_sweep(1'b1, 1, -1, -1);
    fault_kind = 2; fault_idx = 1;       // one stuck at 1
    exit_by_stop = 1'b1;
    run_sweep(1'b1, 1, -1, -1);
    fault_kind = 0;
    exit_by_stop = 1'b0;

    run_sweep(1'b1, 1, PER - 1, -1);     // stop coincides with final check

    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    check_idle("start_stop_idle");
    tick();
    check_idle("start_stop_idle2");

    run_sweep(1'b1, 3, -1, 2 * PER + 6 * T + 1);  // async reset at digit 6 of 3rd sweep

    for (int it = 0; it < 8; it++) begin
      int ns, stop_at;
      ns = 1 + int'($urandom % 2);
      fault_kind = int'($urandom % 3);
      fault_idx = 1 + int'($urandom % 9);
      exit_by_stop = 1'($urandom % 2);
      stop_at = (fault_kind == 0 && ($urandom % 2) == 1) ? int'($urandom % (ns * PER)) : -1;
      run_sweep(1'($urandom % 2), ns, stop_at, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_sweep_ctrl.md
# bcd_sweep_ctrl

Sequencer and self-checker for the `bcd` one-hot decoder. It drives the decoder's `a0..a3` nibble through the BCD digits 0-9, up or down, holding each digit for a programmable dwell time. At the end of each dwell it samples the decoder's `one..nine` outputs and compares them against the expected code. It sits between board-level start/stop controls and the `bcd` instance, and replaces free-running stimulus with a clocked, checkable sweep.

## Interface
- `TICK_DIV`, 4: clock cycles each digit is held (dwell); legal range 2..255.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level-sampled; starts a sweep when in IDLE.
- `stop` in 1: aborts any sweep and returns to IDLE; overrides `start`.
- `dir` in 1: 1 = count up 0→9, 0 = count down 9→0; sampled only when a sweep starts.
- `auto_repeat` in 1: 1 = wrap and sweep again without stopping; sampled every time a sweep ends.
- `err_clr` in 1: in ERR, returns the block to IDLE and clears `err` and `err_digit`.
- `one`..`nine` in 1 each: decoder outputs, sampled at the end of each dwell.
- `a0`..`a3` out 1 each: registered digit driving the decoder; `a0` is the LSB.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when a non-repeating sweep completes with no error.
- `err` out 1: high in ERR (sticky).
- `err_digit` out 4: the digit that failed its check; valid while `err` is high.
- `pass_cnt` out 8: number of sweeps completed with no error; saturates at 255; cleared only by `rst`.

## Operation
- States: IDLE, RUN, ERR.
- Reset: the block enters IDLE. `a0..a3` = 0, `busy` = 0, `done` = 0, `err` = 0, `err_digit` = 0, `pass_cnt` = 0, dwell counter = 0.
- IDLE:
  - If `start` = 1 and `stop` = 0, the block enters RUN.
  - The digit loads 0 when `dir` = 1, or 9 when `dir` = 0.
  - The dwell counter loads 0 and `dir` is latched.
  - `a0..a3` stay 0 while in IDLE.
- RUN:
  - The dwell counter increments every cycle.
  - When the counter reaches `TICK_DIV`-1 (end of dwell), the decoder outputs are checked against the current digit:
    - digit 0: all of `one..nine` must be 0;
    - digit d (1..9): only output d may be 1;
    - digit values 10-15 are never generated.
  - Check mismatch: the block enters ERR, `err_digit` ← current digit, and `a0..a3` hold their value.
  - Check match, digit not last (9 for up, 0 for down): digit steps by ±1 and the counter resets to 0.
  - Check match on the last digit:
    - `pass_cnt` increments (saturating at 255).
    - If `auto_repeat` = 1: the digit wraps (9→0 up, 0→9 down) and the block stays in RUN.
    - Otherwise: `done` pulses, the block enters IDLE, and `a0..a3` ← 0.
  - `stop` = 1: the block enters IDLE next cycle, `a0..a3` ← 0, and no `done` pulses. If `stop` arrives in the same cycle as the final check, `stop` wins: no `done`, no `pass_cnt` increment.
- ERR:
  - Outputs hold.
  - `err_clr` or `stop` returns the block to IDLE, with `err` ← 0, `err_digit` ← 0 and `a0..a3` ← 0.
  - `start` is ignored in ERR.
- `rst` asserted mid-sweep forces the reset values immediately, without waiting for a clock edge.

## Timing
- `start` is sampled at edge N. From edge N: state = RUN, `busy` = 1, and the first digit is on `a0..a3`.
- Each digit is held on `a0..a3` for exactly `TICK_DIV` cycles.
- The check samples the decoder in the last cycle of the dwell. The decoder is combinational, so it has settled `TICK_DIV`-1 cycles after the digit change.
- A full sweep lasts 10×`TICK_DIV` cycles. `done` is high for exactly the one cycle after the final sampling edge, coincident with `busy` = 0.
- An error is flagged at the edge that ends the failing dwell: from that edge, `err` = 1 and `busy` = 0.
- `stop` takes effect at the next edge, so the abort latency is 1 cycle.
- With `auto_repeat` = 1, there is no gap between sweeps: the wrapped digit appears at the edge right after the last check.

## Test plan
- `TICK_DIV`=4, `dir`=1, correct `bcd` model, one-cycle `start`:
  - `a0..a3` = 0,1,...,9, each held 4 cycles;
  - `done` pulses at cycle 40 after start;
  - `pass_cnt` = 1, `busy` = 0, `a0..a3` = 0.
- `dir`=0, `auto_repeat`=1, run 3 sweeps:
  - sequence 9→0, 9→0, 9→0 with no gap between sweeps;
  - `done` never asserts;
  - `pass_cnt` = 3.
  - Then `stop`: IDLE next cycle, `a0..a3` = 0.
- Fault model with `five` stuck at 0, `dir`=1:
  - `err` rises at the end of digit 5's dwell (cycle 24);
  - `err_digit` = 5, `a0..a3` hold 5, `busy` = 0;
  - `start` is ignored;
  - `err_clr` → IDLE with `err` = 0.
- Fault model with `one` stuck at 1:
  - the digit-0 check fails;
  - `err_digit` = 0, `err` rises at cycle 4.
- `stop` and the final check in the same cycle:
  - IDLE, no `done`, `pass_cnt` unchanged.
  - `start` and `stop` together in IDLE: the block stays in IDLE.
- `rst` pulse asynchronous to `clk`, mid-sweep at digit 6 after 2 completed sweeps:
  - all outputs are 0 immediately, before the next clock edge;
  - `pass_cnt` = 0.
